// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types, width defaults and helpers for the two-port SRAM initiator
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF / RESP_DEPTH_DEF : default geometry of the 64 x 24 macro
//   port_req_t                               : one request (write, addr, wdata)
//   cnt_w()                                  : width of a count that must reach depth
//   CNT_W_DEF                                : FIFO count width for the default depth
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF     = 6;
    localparam int DATA_W_DEF     = 24;
    localparam int RESP_DEPTH_DEF = 2;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } port_req_t;

    // A count of 0..depth inclusive needs one more code than depth entries.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w(RESP_DEPTH_DEF);

endpackage

// File: rtl/sram2rw_port_ctrl_if.sv
// rtl/sram2rw_port_ctrl_if.sv - one request/response channel of the two-port SRAM initiator
//
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata : request handshake
//   resp_valid/resp_ready/resp_rdata                 : read response handshake
// Modports:
//   master : the requester (cache/tag logic)
//   slave  : the controller
interface sram2rw_port_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - first-word fall-through response FIFO with occupancy count
//
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   push, push_data     : write side (never pushed while full; caller enforces credits)
//   pop                 : consume the word presented on out_data
//   out_valid, out_data : head of queue; a push into an empty FIFO shows up the same cycle
//   count               : stored entries (a same-cycle fall-through word is not counted)
module sram_resp_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              store;
    logic              drain;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign out_valid = ~empty | push;
    // Zero when idle so the response data reads 0 out of reset.
    assign out_data  = ~empty ? mem[rd_ptr] : (push ? push_data : '0);

    // Push and pop on an empty FIFO is a pure pass-through: nothing is stored.
    assign store = push & ~(empty & pop);
    assign drain = pop & ~empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= ptr_inc(wr_ptr);
            if (drain) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(store) - CNT_W'(drain);
        end
    end

    always_ff @(posedge clock) begin
        if (store) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram2rw_port_ctrl.sv
// rtl/sram2rw_port_ctrl.sv - dual valid/ready initiator for a two-port 64x24 SRAM macro
//
// Ports:
//   clock, reset_n       : sole clock (also the macro clock), asynchronous active-low reset
//   a, b                 : request/response channels; a drives macro port 1, b drives port 2
//   sram_csb1/2          : macro chip select, active-low
//   sram_web1/2          : macro write enable, active-low
//   sram_oeb1/2          : macro read enable, active-low
//   sram_a1/2, sram_i1/2 : macro address / write data (hold last value when idle)
//   sram_o1/2            : macro registered read data (valid the cycle after a read)
// Build option:
//   SRAM_CTRL_BYPASS_EN  : a same-cycle, same-address read/write across ports returns the
//                          write data instead of the macro's old data
module sram2rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sram2rw_port_ctrl_if.slave   a,
    sram2rw_port_ctrl_if.slave   b,
    output logic                 sram_csb1,
    output logic                 sram_web1,
    output logic                 sram_oeb1,
    output logic [ADDR_W-1:0]    sram_a1,
    output logic [DATA_W-1:0]    sram_i1,
    input  logic [DATA_W-1:0]    sram_o1,
    output logic                 sram_csb2,
    output logic                 sram_web2,
    output logic                 sram_oeb2,
    output logic [ADDR_W-1:0]    sram_a2,
    output logic [DATA_W-1:0]    sram_i2,
    input  logic [DATA_W-1:0]    sram_o2
);

    localparam int CNT_W = cnt_w(RESP_DEPTH);

    logic              a_ready, b_ready;
    logic              a_acc, b_acc;
    logic              a_inflight, b_inflight;
    logic              a_pop, b_pop;
    logic [CNT_W-1:0]  a_cnt, b_cnt;
    logic [CNT_W:0]    a_occ, b_occ;
    logic              same_addr, collision;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q;
    logic [DATA_W-1:0] a_wdata_q, b_wdata_q;
    logic [DATA_W-1:0] a_push_data, b_push_data;

    // Credits: stored responses plus the read whose data lands next cycle. A pop this
    // cycle frees its slot immediately, so ready can rise while a response drains.
    assign a_occ = {1'b0, a_cnt} + (CNT_W+1)'(a_inflight) - (CNT_W+1)'(a_pop);
    assign b_occ = {1'b0, b_cnt} + (CNT_W+1)'(b_inflight) - (CNT_W+1)'(b_pop);

    // Two writes to one word in one cycle: port a wins, port b retries next cycle.
    assign same_addr = (a.req_addr == b.req_addr);
    assign collision = a.req_valid & b.req_valid & a.req_write & b.req_write & same_addr;

    assign a_ready = reset_n & (a_occ < (CNT_W+1)'(RESP_DEPTH));
    assign b_ready = reset_n & (b_occ < (CNT_W+1)'(RESP_DEPTH)) & ~collision;

    assign a.req_ready = a_ready;
    assign b.req_ready = b_ready;
    assign a_acc = a.req_valid & a_ready;
    assign b_acc = b.req_valid & b_ready;

    // Macro drive: strobes only in the accept cycle; address/data hold when idle.
    assign sram_csb1 = ~a_acc;
    assign sram_web1 = ~(a_acc & a.req_write);
    assign sram_oeb1 = ~(a_acc & ~a.req_write);
    assign sram_a1   = a_acc ? a.req_addr : a_addr_q;
    assign sram_i1   = (a_acc & a.req_write) ? a.req_wdata : a_wdata_q;

    assign sram_csb2 = ~b_acc;
    assign sram_web2 = ~(b_acc & b.req_write);
    assign sram_oeb2 = ~(b_acc & ~b.req_write);
    assign sram_a2   = b_acc ? b.req_addr : b_addr_q;
    assign sram_i2   = (b_acc & b.req_write) ? b.req_wdata : b_wdata_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_inflight <= 1'b0;
            b_inflight <= 1'b0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            a_wdata_q  <= '0;
            b_wdata_q  <= '0;
        end else begin
            a_inflight <= a_acc & ~a.req_write;
            b_inflight <= b_acc & ~b.req_write;
            if (a_acc)               a_addr_q  <= a.req_addr;
            if (b_acc)               b_addr_q  <= b.req_addr;
            if (a_acc & a.req_write) a_wdata_q <= a.req_wdata;
            if (b_acc & b.req_write) b_wdata_q <= b.req_wdata;
        end
    end

`ifdef SRAM_CTRL_BYPASS_EN
    logic              a_byp_q, b_byp_q;
    logic [DATA_W-1:0] a_byp_data, b_byp_data;

    // The macro returns old data on a read/write race; remember the racing write so the
    // response can carry the new word instead.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_byp_q    <= 1'b0;
            b_byp_q    <= 1'b0;
            a_byp_data <= '0;
            b_byp_data <= '0;
        end else begin
            a_byp_q    <= a_acc & ~a.req_write & b_acc & b.req_write & same_addr;
            b_byp_q    <= b_acc & ~b.req_write & a_acc & a.req_write & same_addr;
            a_byp_data <= b.req_wdata;
            b_byp_data <= a.req_wdata;
        end
    end

    assign a_push_data = a_byp_q ? a_byp_data : sram_o1;
    assign b_push_data = b_byp_q ? b_byp_data : sram_o2;
`else
    assign a_push_data = sram_o1;
    assign b_push_data = sram_o2;
`endif

    assign a_pop = a.resp_valid & a.resp_ready;
    assign b_pop = b.resp_valid & b.resp_ready;

    sram_resp_fifo #(.DATA_W(DATA_W), .DEPTH(RESP_DEPTH), .CNT_W(CNT_W)) u_a_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (a_inflight),
        .push_data (a_push_data),
        .pop       (a_pop),
        .out_valid (a.resp_valid),
        .out_data  (a.resp_rdata),
        .count     (a_cnt)
    );

    sram_resp_fifo #(.DATA_W(DATA_W), .DEPTH(RESP_DEPTH), .CNT_W(CNT_W)) u_b_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (b_inflight),
        .push_data (b_push_data),
        .pop       (b_pop),
        .out_valid (b.resp_valid),
        .out_data  (b.resp_rdata),
        .count     (b_cnt)
    );

endmodule
